// File: rtl/flash_read_ctrl.sv
// Boot-time NOR flash read responder: issues the Read Array init command, then serves level-held read requests.
// Latency: request accepted at edge E0, done pulses in the cycle after edge E0+RD_WAIT; RD_WAIT+2 cycles per read.
// Backpressure: req is only sampled in IDLE; a request held high waits through init and between back-to-back reads.
module flash_read_ctrl #(
  parameter int RD_WAIT  = 4,
  parameter int WE_PULSE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [21:0] addr,
  output logic        done,
  output logic [15:0] data,
  output logic [15:0] done_addr,
  output logic        ready,
  output logic [21:0] flash_a,
  inout  wire  [15:0] flash_dq,
  output logic        flash_ce_n,
  output logic        flash_oe_n,
  output logic        flash_we_n,
  output logic        flash_byte_n,
  output logic        flash_vpen,
  output logic        flash_rp_n
);

  // One shared counter covers the WE pulse, the read wait and the two-step setup.
  localparam int CNT_MAX = (RD_WAIT > WE_PULSE) ? ((RD_WAIT > 2) ? RD_WAIT : 2)
                                                : ((WE_PULSE > 2) ? WE_PULSE : 2);
  localparam int CW = $clog2(CNT_MAX);

  localparam logic [CW-1:0] RD_LAST  = CW'(RD_WAIT - 1);
  localparam logic [CW-1:0] WE_LAST  = CW'(WE_PULSE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [15:0]   READ_ARRAY_CMD = 16'h00FF;

  typedef enum logic [2:0] {
    S_INIT_SETUP,
    S_INIT_WE,
    S_INIT_HOLD,
    S_IDLE,
    S_READ,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;
  logic [15:0]   data_q;
  logic [15:0]   done_addr_q;
  logic [15:0]   pend_q;
  logic          ready_q;
  logic [21:0]   flash_a_q;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          dq_oe_q;

  // Single FSM: every flash pin and handshake output is a register updated with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT_SETUP;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      data_q      <= '0;
      done_addr_q <= '0;
      pend_q      <= '0;
      ready_q     <= 1'b0;
      flash_a_q   <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        // The reset-held cycle already sits in INIT_SETUP with the bus quiet, so the
        // first free edge arms the setup drive and the second one starts the WE pulse.
        S_INIT_SETUP: begin
          if (cnt_q == '0) begin
            cnt_q     <= CNT_ONE;
            ce_n_q    <= 1'b0;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            dq_oe_q   <= 1'b1;
            flash_a_q <= '0;
          end else begin
            cnt_q   <= '0;
            we_n_q  <= 1'b0;
            state_q <= S_INIT_WE;
          end
        end
        S_INIT_WE: begin
          if (cnt_q == WE_LAST) begin
            cnt_q   <= '0;
            we_n_q  <= 1'b1;
            state_q <= S_INIT_HOLD;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        // Data hold after WE# rises; the bus is released on the way into IDLE.
        S_INIT_HOLD: begin
          ce_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        S_IDLE: begin
          if (req) begin
            flash_a_q <= addr;
            pend_q    <= addr[15:0];
            ce_n_q    <= 1'b0;
            oe_n_q    <= 1'b0;
            state_q   <= S_READ;
          end
        end
        S_READ: begin
          if (cnt_q == RD_LAST) begin
            cnt_q       <= '0;
            data_q      <= flash_dq;
            done_addr_q <= pend_q;
            done_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          state_q <= S_INIT_SETUP;
        end
      endcase
    end
  end

  assign done         = done_q;
  assign data         = data_q;
  assign done_addr    = done_addr_q;
  assign ready        = ready_q;
  assign flash_a      = flash_a_q;
  assign flash_ce_n   = ce_n_q;
  assign flash_oe_n   = oe_n_q;
  assign flash_we_n   = we_n_q;
  assign flash_dq     = dq_oe_q ? READ_ARRAY_CMD : 16'hzzzz;
  assign flash_byte_n = 1'b1;
  assign flash_vpen   = 1'b0;
  assign flash_rp_n   = ~rst;

`ifndef SYNTHESIS
  // The flash must never drive the bus while we do, and never see OE# with WE#.
  a_no_contention: assert property (@(posedge clk) disable iff (rst)
    !(!oe_n_q && (!we_n_q || dq_oe_q)));
  // Bus drive only happens while issuing the init command.
  a_dq_init_only: assert property (@(posedge clk) disable iff (rst)
    dq_oe_q |-> (state_q inside {S_INIT_SETUP, S_INIT_WE, S_INIT_HOLD}));
  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    done_q |=> !done_q);
`endif

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Randomized bench for flash_read_ctrl with a behavioural flash and a read-level reference.
// Expected data comes from a fixed address-to-word function; timing from the handshake rules.
// Requester drops req on the edge that samples done, or holds it for back-to-back reads.
module tb_flash_read_ctrl;

  localparam int RD_WAIT  = 4;
  localparam int WE_PULSE = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [21:0] addr = '0;
  logic        done;
  logic [15:0] data;
  logic [15:0] done_addr;
  logic        ready;
  logic [21:0] flash_a;
  wire  [15:0] flash_dq;
  logic        flash_ce_n;
  logic        flash_oe_n;
  logic        flash_we_n;
  logic        flash_byte_n;
  logic        flash_vpen;
  logic        flash_rp_n;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_done = 0;
  int done_seen = 0;
  int cyc = 0;
  int done_cyc = 0;
  logic [21:0] cur_addr = '0;

  flash_read_ctrl #(.RD_WAIT(RD_WAIT), .WE_PULSE(WE_PULSE)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .addr        (addr),
    .done        (done),
    .data        (data),
    .done_addr   (done_addr),
    .ready       (ready),
    .flash_a     (flash_a),
    .flash_dq    (flash_dq),
    .flash_ce_n  (flash_ce_n),
    .flash_oe_n  (flash_oe_n),
    .flash_we_n  (flash_we_n),
    .flash_byte_n(flash_byte_n),
    .flash_vpen  (flash_vpen),
    .flash_rp_n  (flash_rp_n)
  );

  always #5 clk = ~clk;

  // Flash contents: one fixed word at address 5, a scrambled function of the address elsewhere.
  function automatic logic [15:0] word_at(input logic [21:0] a);
    if (a == 22'h000005) return 16'h1234;
    return a[15:0] ^ {a[21:16], 10'h2C9} ^ 16'hA55A;
  endfunction

  logic [15:0] model_out;
  assign model_out = word_at(flash_a);
  assign flash_dq  = (!flash_ce_n && !flash_oe_n) ? model_out : 16'hzzzz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc++;

  // Cycle-level invariants that hold at every sample point.
  always @(negedge clk) begin
    if (done) done_seen++;
    chk("oe_we_overlap", 32'(!flash_oe_n && !flash_we_n), 32'd0);
    chk("oe_before_ready", 32'(!flash_oe_n && !ready), 32'd0);
    chk("byte_n", 32'(flash_byte_n), 32'd1);
    chk("vpen", 32'(flash_vpen), 32'd0);
    chk("rp_n", 32'(flash_rp_n), 32'(!rst));
    if (!flash_oe_n) chk("flash_a_read", 32'(flash_a), 32'(cur_addr));
  end

  task automatic apply_reset(input int n);
    rst = 1'b1;
    req = 1'b0;
    repeat (n) tick();
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_done_addr", 32'(done_addr), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_flash_a", 32'(flash_a), 32'd0);
    chk("rst_ce_n", 32'(flash_ce_n), 32'd1);
    chk("rst_oe_n", 32'(flash_oe_n), 32'd1);
    chk("rst_we_n", 32'(flash_we_n), 32'd1);
    tick();
    rst = 1'b0;
  endtask

  // Called right after reset release; returns at the sample point of the first IDLE cycle.
  task automatic check_init(input string tag);
    int first_ce = -1, last_ce = -1, first_we = -1, last_we = -1;
    int n_ce = 0, n_we = 0, oe_low = 0, bad_dq = 0, bad_a = 0, rdy = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        rdy = i;
        break;
      end
      if (!flash_oe_n) oe_low++;
      if (!flash_ce_n) begin
        if (first_ce < 0) first_ce = i;
        last_ce = i;
        n_ce++;
        if (flash_dq !== 16'h00FF) bad_dq++;
        if (flash_a !== 22'h0) bad_a++;
      end
      if (!flash_we_n) begin
        if (first_we < 0) first_we = i;
        last_we = i;
        n_we++;
      end
    end
    chk({tag, "_ready_seen"}, 32'(rdy >= 0), 32'd1);
    chk({tag, "_start"}, 32'(first_ce), 32'd1);
    chk({tag, "_we_cycles"}, 32'(n_we), 32'(WE_PULSE));
    chk({tag, "_we_span"}, 32'(last_we - first_we + 1), 32'(WE_PULSE));
    chk({tag, "_setup"}, 32'(first_we - first_ce), 32'd1);
    chk({tag, "_hold"}, 32'(last_ce - last_we), 32'd1);
    chk({tag, "_ce_cycles"}, 32'(n_ce), 32'(WE_PULSE + 2));
    chk({tag, "_ready_rise"}, 32'(rdy - first_ce), 32'(WE_PULSE + 2));
    chk({tag, "_oe_low"}, 32'(oe_low), 32'd0);
    chk({tag, "_dq_cmd"}, 32'(bad_dq), 32'd0);
    chk({tag, "_a_zero"}, 32'(bad_a), 32'd0);
    chk({tag, "_idle_ce"}, 32'(flash_ce_n), 32'd1);
  endtask

  // Waits for done, checks latency and returned word; scrambles addr after acceptance.
  task automatic wait_read(input logic [21:0] a, input string tag, input int exp_lat);
    int lat = -1;
    for (int i = 1; i <= exp_lat + 6; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        done_cyc = cyc;
        break;
      end
      if (i == 2) addr = ~a;
    end
    exp_done++;
    chk({tag, "_done"}, 32'(lat > 0), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_data"}, 32'(data), 32'(word_at(a)));
    chk({tag, "_done_addr"}, 32'(done_addr), 32'(a[15:0]));
  endtask

  // Starts just after a posedge with the DUT idle; ends at the sample point of the following IDLE cycle.
  task automatic read_once(input logic [21:0] a, input string tag);
    addr = a;
    cur_addr = a;
    req = 1'b1;
    wait_read(a, tag, RD_WAIT + 2);
    tick();
    req = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [21:0] a;
    int prev_cyc;

    // Reset and a clean init sequence with no request pending.
    apply_reset(3);
    check_init("init1");

    // Request raised during init is served in the first IDLE cycle.
    apply_reset(2);
    addr = 22'h000005;
    cur_addr = 22'h000005;
    req = 1'b1;
    check_init("init2");
    wait_read(22'h000005, "early", RD_WAIT + 1);
    tick();
    req = 1'b0;
    @(negedge clk);
    chk("early_pulse", 32'(done), 32'd0);

    // Reassert one cycle after dropping.
    tick();
    read_once(22'h000006, "reassert");

    // req held continuously, address stepped on every done.
    tick();
    a = 22'($urandom());
    addr = a;
    cur_addr = a;
    req = 1'b1;
    prev_cyc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_read(a, "stream", (k == 0) ? RD_WAIT + 2 : RD_WAIT + 1);
      if (k > 0) chk("stream_period", 32'(done_cyc - prev_cyc), 32'(RD_WAIT + 2));
      prev_cyc = done_cyc;
      tick();
      if (k == 4) begin
        req = 1'b0;
      end else begin
        a = 22'($urandom());
        addr = a;
        cur_addr = a;
      end
      @(negedge clk);
      chk("stream_pulse", 32'(done), 32'd0);
    end

    // Top of the address range: flash_a verbatim, done_addr truncated.
    tick();
    read_once(22'h3FFFFF, "wrap");
    chk("wrap_done_addr", 32'(done_addr), 32'h0000FFFF);

    // Reset in the second READ cycle aborts the read and re-runs init.
    tick();
    a = 22'($urandom());
    addr = a;
    cur_addr = a;
    req = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("abort_in_read", 32'(flash_oe_n), 32'd0);
    apply_reset(1);
    check_init("init3");
    tick();
    read_once(22'($urandom()), "post_rst");

    // Random reads with random idle gaps.
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      tick();
      read_once(22'($urandom()), "rand");
    end

    tick();
    chk("done_total", 32'(done_seen), 32'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got time limit expected finish");
    $fatal(1);
  end

endmodule

// File: doc/flash_read_ctrl.md
Name: flash_read_ctrl

Overview:
- Responder side of the boot-time flash request/done handshake.
- Accepts a level-held read request with a 22-bit word address and drives the board's 16-bit parallel NOR flash (StrataFlash-style, Read Array command 0x00FF).
- Returns the read word with a one-cycle done pulse and echoes the low 16 address bits so the requester can derive the RAM destination.
- Sits between the bootloader and the flash pins.

Parameters:
- RD_WAIT, 4, cycles CE#/OE# held low before data capture (≥1)
- WE_PULSE, 3, cycles WE# held low for the init command (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- req  in  1  read request, level; held by requester until done is seen
- addr  in  22  word address [22:1], sampled when request accepted
- done  out  1  one-cycle pulse; data/done_addr valid from this cycle
- data  out  16  captured flash word, held until next capture
- done_addr  out  16  addr[16:1] of the completed read
- ready  out  1  high once the init command has completed
- flash_a  out  22  flash address [22:1]
- flash_dq  inout  16  flash data bus, driven only during the init command
- flash_ce_n  out  1  chip enable, active-low
- flash_oe_n  out  1  output enable, active-low
- flash_we_n  out  1  write enable, active-low
- flash_byte_n  out  1  constant 1 (x16 mode)
- flash_vpen  out  1  constant 0 (programming disabled)
- flash_rp_n  out  1  0 while rst is high, else 1

Behaviour:
- States: INIT_SETUP, INIT_WE, INIT_HOLD, IDLE, READ, DONE.
- Reset (rst=1 at an edge) forces INIT_SETUP from any state, including mid-read.
  - Outputs after reset: done=0, data=0, done_addr=0, ready=0, flash_a=0.
  - ce_n, oe_n and we_n are 1; dq is released; counters are 0.
- INIT_SETUP (1 cycle): ce_n=0, oe_n=1, we_n=1, flash_a=0, dq driven 0x00FF.
- INIT_WE (WE_PULSE cycles): as INIT_SETUP but we_n=0.
- INIT_HOLD (1 cycle): we_n=1, dq still driven 0x00FF, ce_n=0. Next state is IDLE; ready=1 from IDLE onward and stays 1 until the next reset.
- IDLE: ce_n/oe_n/we_n=1, dq released.
  - If req=1 at an edge: latch addr into flash_a and addr[16:1] into a pending register, then go to READ.
  - A req that arrives during init stays pending (level) and is accepted in the first IDLE cycle.
- READ (RD_WAIT cycles): ce_n=0, oe_n=0, we_n=1, flash_a stable.
  - At the edge ending the last READ cycle: data<=flash_dq, done_addr<=pending, go to DONE.
- DONE (1 cycle): done=1, ce_n=oe_n=1. Next state is IDLE unconditionally.
- Latency: req accepted at edge E0; done is high in the cycle after edge E0+RD_WAIT. Each read occupies RD_WAIT+2 cycles minimum, IDLE included.
- Handshake rule:
  - The requester drops req on the edge where it samples done=1.
  - req is evaluated only in IDLE; a req still high in IDLE starts a new read, so back-to-back reads are legal.
  - addr must be stable from req assertion until acceptance. Changes to addr after acceptance are ignored.
- Bus-contention rule:
  - dq is driven only in INIT_* states.
  - oe_n is never 0 in the same cycle as we_n=0 or a driven dq.
- Address wrap: flash_a is taken verbatim. done_addr is a truncation, so 0x3FFFFF yields 0xFFFF; no other arithmetic.
- Reset mid-READ: no done is issued, data keeps 0, and init re-runs before any new read.
- Counters are sized for the parameters; a counter reaching its terminal value moves the state and clears the counter.

Test Plan:
- Reset release, req=0 -> we_n low for exactly 3 cycles with dq=0x00FF and flash_a=0; ready rises after 5 cycles; oe_n stays 1 throughout init.
- req=1 during init, addr=0x000005, flash model returns 0x1234 -> read accepted in the first IDLE cycle; done pulses once 4 edges later with data=0x1234, done_addr=0x0005.
- Requester drops req on done, reasserts one cycle later with addr=0x000006 -> second done follows with data from 0x000006, done_addr=0x0006; no extra done pulses.
- req held high continuously, addr stepped on each done -> one done per 6 cycles; no flash_dq drive at any point after init.
- addr=0x3FFFFF -> flash_a=0x3FFFFF during READ, done_addr=0xFFFF.
- rst asserted in the 2nd READ cycle -> done never pulses; ce_n/oe_n=1 at the next edge; init sequence repeats; ready=0 until it completes.
